// File: rtl/ss_rp_16b_pkg.sv
// ---------------------------------------------------------------------------
// ss_rp_16b_pkg
// Shared definitions for the return-pointer register of the 16-bit stack
// subsystem: the offset-select encoding and the reset value of the pointer.
// ---------------------------------------------------------------------------
package ss_rp_16b_pkg;

  localparam int RP_WIDTH = 16;

  // Offset select carried on rp_src.
  typedef enum logic [1:0] {
    RP_SRC_ADD0 = 2'd0,  // rp <= add
    RP_SRC_INC  = 2'd1,  // rp <= add + 1
    RP_SRC_DEC  = 2'd2,  // rp <= add - 1
    RP_SRC_HOLD = 2'd3   // rp <= rp
  } rp_src_e;

  localparam logic [RP_WIDTH-1:0] RP_RESET_VAL = 16'h0000;

endpackage : ss_rp_16b_pkg

// File: rtl/ss_rp_16b_rp_offset_adder.sv
// ---------------------------------------------------------------------------
// rp_offset_adder
// Combinational offset stage of the return-pointer register. Turns the
// offset select into a two's-complement offset of 0, +1 or -1 and adds it
// to the base value. Arithmetic is modulo 2^WIDTH; carry/borrow is dropped.
//
// Ports:
//   add     in  [WIDTH-1:0]  base value
//   rp_src  in  [1:0]        offset select (hold/unknown -> offset 0)
//   next    out [WIDTH-1:0]  add + offset
// ---------------------------------------------------------------------------
module rp_offset_adder
  import ss_rp_16b_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] add,
  input  logic [1:0]       rp_src,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] offset;

  // -1 is all ones, so a plain WIDTH-bit add implements the decrement and
  // the wrap at both ends falls out of the truncation.
  always_comb begin
    offset = '0;
    case (rp_src)
      RP_SRC_INC: offset = WIDTH'(1);
      RP_SRC_DEC: offset = '1;
      default:    offset = '0;
    endcase
  end

  assign next = add + offset;

endmodule : rp_offset_adder

// File: rtl/ss_rp_16b.sv
// ---------------------------------------------------------------------------
// ss_rp_16b
// Return-pointer register for the stack subsystem. Every rising clock edge
// it loads add, add+1 or add-1 (the offset is applied to add, never to the
// previous rp), or holds its value. Reset is asynchronous and overrides all
// selects; release is sampled by CLK.
//
// Ports:
//   CLK     in            system clock, rising edge
//   reset   in            asynchronous reset, active low
//   add     in  [WIDTH-1:0]  base value
//   rp_src  in  [1:0]        0:+0  1:+1  2:-1  3:hold
//   rp      out [WIDTH-1:0]  registered return pointer
// ---------------------------------------------------------------------------
module ss_rp_16b
  import ss_rp_16b_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = RP_RESET_VAL
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] add,
  input  logic [1:0]       rp_src,
  output logic [WIDTH-1:0] rp
);

  logic [WIDTH-1:0] next;

  rp_offset_adder #(
    .WIDTH (WIDTH)
  ) u_offset_adder (
    .add    (add),
    .rp_src (rp_src),
    .next   (next)
  );

  // Only the three load encodings update rp; hold and any unknown select
  // fall through to the default and keep the current value.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rp <= RESET_VAL;
    end else begin
      case (rp_src)
        RP_SRC_ADD0,
        RP_SRC_INC,
        RP_SRC_DEC: rp <= next;
        default:    rp <= rp;
      endcase
    end
  end

endmodule : ss_rp_16b

// File: tb/tb_ss_rp_16b.sv
module tb_ss_rp_16b;

  logic        clk;
  logic        reset;
  logic [15:0] add;
  logic [1:0]  rp_src;
  logic [15:0] rp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_rp;

  ss_rp_16b dut (
    .CLK    (clk),
    .reset  (reset),
    .add    (add),
    .rp_src (rp_src),
    .rp     (rp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Next pointer from the rules: base plus offset, modulo 65536; 3 holds.
  function automatic logic [15:0] ref_next(input logic [15:0] cur,
                                           input logic [15:0] a,
                                           input logic [1:0]  s);
    int v;
    case (s)
      2'd0:    v = int'(a);
      2'd1:    v = (int'(a) + 1) % 65536;
      2'd2:    v = (int'(a) - 1 + 65536) % 65536;
      default: v = int'(cur);
    endcase
    return v[15:0];
  endfunction

  // ---------------- driver ----------------
  // Drive at the falling edge, let one rising edge pass, settle, update model.
  task automatic step(input logic [15:0] a, input logic [1:0] s);
    @(negedge clk);
    add    = a;
    rp_src = s;
    @(posedge clk);
    #1;
    if (!reset) model_rp = 16'h0000;
    else        model_rp = ref_next(model_rp, a, s);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(16'h1234, 2'd1);
      n_checks++;
      if (rp !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: rp=%h expected=%h", i, rp, 16'h0000);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    step(16'h1234, 2'd1);
    n_checks++;
    if (rp !== 16'h1235) begin
      n_fail++;
      $display("FAIL reset_release: rp=%h expected=%h", rp, 16'h1235);
    end
  endtask

  task automatic test_select_sweep();
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h0001; exp_v[1] = 16'h0002; exp_v[2] = 16'h0000;
    for (int s = 0; s < 3; s++) begin
      step(16'h0001, 2'(s));
      n_checks++;
      if (rp !== exp_v[s] || rp !== model_rp) begin
        n_fail++;
        $display("FAIL select_sweep[src=%0d]: rp=%h expected=%h", s, rp, exp_v[s]);
      end
    end
  endtask

  task automatic test_hold();
    step(16'h00A5, 2'd0);
    n_checks++;
    if (rp !== 16'h00A5) begin
      n_fail++;
      $display("FAIL hold_load: rp=%h expected=%h", rp, 16'h00A5);
    end
    for (int i = 0; i < 3; i++) begin
      step(16'h5555, 2'd3);
      n_checks++;
      if (rp !== 16'h00A5) begin
        n_fail++;
        $display("FAIL hold[%0d]: rp=%h expected=%h", i, rp, 16'h00A5);
      end
    end
  endtask

  task automatic test_wrap();
    step(16'hFFFF, 2'd1);
    n_checks++;
    if (rp !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_inc: rp=%h expected=%h", rp, 16'h0000);
    end
    step(16'h0000, 2'd2);
    n_checks++;
    if (rp !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_dec: rp=%h expected=%h", rp, 16'hFFFF);
    end
  endtask

  task automatic test_async_reset();
    step(16'h0042, 2'd0);
    n_checks++;
    if (rp !== 16'h0042) begin
      n_fail++;
      $display("FAIL async_pre: rp=%h expected=%h", rp, 16'h0042);
    end
    // Pending load of add+1 is set up, then reset drops between edges.
    add    = 16'h0777;
    rp_src = 2'd1;
    #2;
    reset = 1'b0;
    #1;
    model_rp = 16'h0000;
    n_checks++;
    if (rp !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_clear: rp=%h expected=%h", rp, 16'h0000);
    end
    for (int i = 0; i < 2; i++) begin
      step(16'h0777, 2'd1);
      n_checks++;
      if (rp !== 16'h0000) begin
        n_fail++;
        $display("FAIL async_stay[%0d]: rp=%h expected=%h", i, rp, 16'h0000);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    step(16'h0777, 2'd1);
    n_checks++;
    if (rp !== 16'h0778) begin
      n_fail++;
      $display("FAIL async_release: rp=%h expected=%h", rp, 16'h0778);
    end
  endtask

  task automatic test_non_accum();
    for (int i = 0; i < 4; i++) begin
      step(16'h0010, 2'd1);
      n_checks++;
      if (rp !== 16'h0011) begin
        n_fail++;
        $display("FAIL non_accum[%0d]: rp=%h expected=%h", i, rp, 16'h0011);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [1:0]  s;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 16'hFFFF;
        1:       a = 16'h0000;
        default: a = 16'($urandom_range(0, 65535));
      endcase
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        // Asynchronous reset pulse at a random point before the next edge.
        @(negedge clk);
        #($urandom_range(1, 3));
        reset = 1'b0;
        #1;
        model_rp = 16'h0000;
        n_checks++;
        if (rp !== 16'h0000) begin
          n_fail++;
          $display("FAIL rand_async[%0d]: rp=%h expected=%h", i, rp, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b1;
      end
      step(a, s);
      n_checks++;
      if (rp !== model_rp) begin
        n_fail++;
        $display("FAIL rand[%0d] add=%h src=%0d: rp=%h expected=%h",
                 i, a, s, rp, model_rp);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset    = 1'b0;
    add      = 16'h1234;
    rp_src   = 2'd1;
    model_rp = 16'h0000;
    #1;
    n_checks++;
    if (rp !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_initial: rp=%h expected=%h", rp, 16'h0000);
    end
    test_reset();
    test_select_sweep();
    test_hold();
    test_wrap();
    test_async_reset();
    test_non_accum();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ss_rp_16b
